// File: rtl/line_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_sched_pkg
// Purpose : Shared types and default sizing for the line-buffer scheduler.
//           Holds the scheduler state encoding, default parameter values
//           and the buffer-pointer width derived from the buffer count.
// Rev     : 1.0  initial release
// ============================================================================
package line_sched_pkg;

  localparam int DEF_NUM_BUFS = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DIM_W    = 16;
  localparam int DEF_ADDR_W   = 17;

  localparam int PTR_W = $clog2(DEF_NUM_BUFS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/row_ring_tracker.sv
`default_nettype none
// ============================================================================
// Module  : row_ring_tracker
// Purpose : Ring bookkeeping for the line buffers: write pointer (buffer
//           receiving the next row), read pointer (buffer holding the
//           oldest resident row) and the count of resident complete rows.
// Ports   : clock, reset      - clock, synchronous active-high reset
//           clear             - synchronous restart at frame start
//           push              - a row was completed this cycle
//           pop               - filter asks to release the oldest row
//           pop_accepted      - pop honoured (ring was not empty)
//           wr_ptr, rd_ptr    - physical buffer indices
//           occupancy         - resident complete rows (0..NUM_BUFS)
// Rev     : 1.0  initial release
// ============================================================================
module row_ring_tracker
  import line_sched_pkg::*;
#(
  parameter int NUM_BUFS = DEF_NUM_BUFS,
  localparam int BUF_PTR_W = $clog2(NUM_BUFS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  output logic                 pop_accepted,
  output logic [BUF_PTR_W-1:0] wr_ptr,
  output logic [BUF_PTR_W-1:0] rd_ptr,
  output logic [BUF_PTR_W:0]   occupancy
);

  // A release against an empty ring is dropped silently.
  assign pop_accepted = pop && (occupancy != '0);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      // NUM_BUFS is a power of two, so natural overflow gives the wrap.
      if (push) begin
        wr_ptr <= wr_ptr + BUF_PTR_W'(1);
      end
      if (pop_accepted) begin
        rd_ptr <= rd_ptr + BUF_PTR_W'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop_accepted})
        2'b10:   occupancy <= occupancy + (BUF_PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (BUF_PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : line_buffer_scheduler
// Purpose : Steers the incoming pixel stream row by row into a ring of
//           line-buffer BRAMs, reports to the filter when a window of rows
//           is resident, recycles buffers as rows are released and stalls
//           the writer while every buffer holds an unconsumed row.
// Ports   : clock, reset                - clock, sync active-high reset
//           cfg_valid/cfg_rows/cfg_cols - frame configuration strobe
//           wr_valid/wr_pixel/wr_ready  - pixel stream handshake
//           bram_wren/wraddr/wrdata     - registered BRAM write port
//           rd_window_valid/rd_base_buf/rd_base_row/rd_rows_avail
//                                       - window status to the filter
//           rd_release                  - filter done with the oldest row
//           busy, frame_done            - frame status
// Rev     : 1.0  initial release
// ============================================================================
module line_buffer_scheduler
  import line_sched_pkg::*;
#(
  parameter int NUM_BUFS = DEF_NUM_BUFS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DIM_W    = DEF_DIM_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  localparam int BUF_PTR_W = $clog2(NUM_BUFS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [DIM_W-1:0]     cfg_rows,
  input  logic [DIM_W-1:0]     cfg_cols,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_pixel,
  output logic                 wr_ready,
  output logic [NUM_BUFS-1:0]  bram_wren,
  output logic [ADDR_W-1:0]    bram_wraddr,
  output logic [DATA_W-1:0]    bram_wrdata,
  output logic                 rd_window_valid,
  output logic [BUF_PTR_W-1:0] rd_base_buf,
  output logic [DIM_W-1:0]     rd_base_row,
  output logic [2:0]           rd_rows_avail,
  input  logic                 rd_release,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [BUF_PTR_W:0] FULL_COUNT = NUM_BUFS[BUF_PTR_W:0];

  sched_state_t          r_state;
  logic [DIM_W-1:0]      r_rows;
  logic [DIM_W-1:0]      r_cols;
  logic [DIM_W-1:0]      r_col_cnt;
  logic [DIM_W-1:0]      r_rows_written;
  logic [DIM_W-1:0]      r_rows_released;
  logic [DIM_W-1:0]      r_base_row;
  logic [NUM_BUFS-1:0]   r_wren;
  logic [ADDR_W-1:0]     r_wraddr;
  logic [DATA_W-1:0]     r_wrdata;

  logic [BUF_PTR_W-1:0]  w_wr_ptr;
  logic [BUF_PTR_W-1:0]  w_rd_ptr;
  logic [BUF_PTR_W:0]    w_occupancy;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_row_end;
  logic                  w_row_done;
  logic                  w_last_row;
  logic                  w_release_req;
  logic                  w_pop_ok;
  logic                  w_last_release;

  assign w_start = (r_state == ST_IDLE) && cfg_valid &&
                   (cfg_rows != '0) && (cfg_cols != '0);

  // Stall decision uses registered occupancy, so a release frees a slot
  // for the following cycle only.
  assign wr_ready   = (r_state == ST_RUN) && (w_occupancy < FULL_COUNT);
  assign w_accept   = wr_valid && wr_ready;
  assign w_row_end  = (r_col_cnt == (r_cols - DIM_W'(1)));
  assign w_row_done = w_accept && w_row_end;
  assign w_last_row = ((r_rows_written + DIM_W'(1)) == r_rows);

  assign w_release_req  = rd_release &&
                          ((r_state == ST_RUN) || (r_state == ST_FLUSH));
  assign w_last_release = ((r_rows_released + DIM_W'(1)) == r_rows);

  row_ring_tracker #(
    .NUM_BUFS (NUM_BUFS)
  ) u_ring (
    .clock        (clock),
    .reset        (reset),
    .clear        (w_start),
    .push         (w_row_done),
    .pop          (w_release_req),
    .pop_accepted (w_pop_ok),
    .wr_ptr       (w_wr_ptr),
    .rd_ptr       (w_rd_ptr),
    .occupancy    (w_occupancy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_rows          <= '0;
      r_cols          <= '0;
      r_col_cnt       <= '0;
      r_rows_written  <= '0;
      r_rows_released <= '0;
      r_base_row      <= '0;
      r_wren          <= '0;
      r_wraddr        <= '0;
      r_wrdata        <= '0;
    end else begin
      r_wren <= '0;

      if (w_accept) begin
        r_wren   <= NUM_BUFS'(1) << w_wr_ptr;
        r_wraddr <= ADDR_W'(r_col_cnt);
        r_wrdata <= wr_pixel;
        if (w_row_end) begin
          r_col_cnt      <= '0;
          r_rows_written <= r_rows_written + DIM_W'(1);
        end else begin
          r_col_cnt <= r_col_cnt + DIM_W'(1);
        end
      end

      if (w_pop_ok) begin
        r_base_row      <= r_base_row + DIM_W'(1);
        r_rows_released <= r_rows_released + DIM_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_rows          <= cfg_rows;
            r_cols          <= cfg_cols;
            r_col_cnt       <= '0;
            r_rows_written  <= '0;
            r_rows_released <= '0;
            r_base_row      <= '0;
            r_state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Move on in the same cycle the last row completes so no pixel
          // beyond the frame is accepted.
          if (w_row_done && w_last_row) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((w_pop_ok && w_last_release) || (r_rows_released == r_rows)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bram_wren       = r_wren;
  assign bram_wraddr     = r_wraddr;
  assign bram_wrdata     = r_wrdata;
  assign rd_window_valid = (w_occupancy == FULL_COUNT) ||
                           ((r_state == ST_FLUSH) && (w_occupancy != '0));
  assign rd_base_buf     = w_rd_ptr;
  assign rd_base_row     = r_base_row;
  assign rd_rows_avail   = 3'(w_occupancy);
  assign busy            = (r_state != ST_IDLE);
  assign frame_done      = (r_state == ST_DONE);

endmodule
`default_nettype wire
